mem_access_sequencer: RTL and testbench

- Sequences data-memory loads and stores issued by the pipeline's memory stage onto a word-wide, ready/ack-style data-memory port.
- Consumes the decoder's mem_wEn, MemSize and load_extend_sign fields.
- Stalls the pipeline while an access is outstanding, then returns lane-aligned, sign- or zero-extended load data.
- Splits word-crossing accesses into two beats when the optional feature is compiled in, and reports bus timeouts.

---
 rtl/mem_access_sequencer_pkg.sv | 44 ++++
 rtl/mem_access_sequencer_if.sv | 22 ++
 rtl/mem_access_sequencer_lane_align.sv | 48 ++++
 rtl/mem_access_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_sequencer_pkg.sv
// Shared encodings for the memory-access sequencer: MemSize codes, FSM states,
// lane masks and small helpers for access width and word-crossing detection.
package mem_access_pkg;

    localparam logic [1:0] SIZE_BYTE  = 2'b00;
    localparam logic [1:0] SIZE_HWORD = 2'b01;
    localparam logic [1:0] SIZE_WORD  = 2'b10;
    localparam logic [1:0] SIZE_BAD   = 2'b11;

    localparam logic [3:0] MASK_BYTE  = 4'b0001;
    localparam logic [3:0] MASK_HWORD = 4'b0011;
    localparam logic [3:0] MASK_WORD  = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT1 = 2'd1,
        BEAT2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_BYTE:  return MASK_BYTE;
            SIZE_HWORD: return MASK_HWORD;
            SIZE_WORD:  return MASK_WORD;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE:  return 3'd1;
            SIZE_HWORD: return 3'd2;
            SIZE_WORD:  return 3'd4;
            default:    return 3'd0;
        endcase
    endfunction

    // An access crosses into the next word when its last byte lies past lane 3.
    function automatic logic crosses_word(input logic [1:0] off, input logic [1:0] size);
        return ({1'b0, off} + size_bytes(size)) > 3'd4;
    endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Word-wide ready/ack data-memory port between the sequencer (master) and memory (slave).
interface mem_access_sequencer_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_access_sequencer_lane_align.sv
// Combinational lane steering: byte enables and write shifts for the current beat,
// plus merge, masking and sign/zero extension of the (up to two) read beats.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic        second_beat,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_lo,
    input  logic [31:0] rdata_hi,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_value
);

    logic [5:0]  sh_lo;
    logic [5:0]  sh_hi;
    logic [3:0]  mask;
    logic [31:0] merged;

    assign sh_lo  = {1'b0, off, 3'b000};
    assign sh_hi  = 6'd32 - sh_lo;
    assign mask   = size_mask(size);
    // With off == 0 the high shift is a full 32 bits, which yields zero.
    assign merged = (rdata_lo >> sh_lo) | (rdata_hi << sh_hi);

    always_comb begin
        if (second_beat) begin
            be         = mask >> (3'd4 - {1'b0, off});
            lane_wdata = wdata >> sh_hi;
        end else begin
            be         = mask << off;
            lane_wdata = wdata << sh_lo;
        end
    end

    always_comb begin
        load_value = merged;
        case (size)
            SIZE_BYTE:  load_value = {{24{sign_ext & merged[7]}}, merged[7:0]};
            SIZE_HWORD: load_value = {{16{sign_ext & merged[15]}}, merged[15:0]};
            default:    load_value = merged;
        endcase
    end

endmodule

// File: rtl/mem_access_sequencer.sv
// Memory-stage load/store sequencer with stall, timeout and lane alignment.
// Define MISALIGN_SPLIT_EN to split word-crossing accesses into two beats.
module mem_access_sequencer
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   op_valid,
    input  logic                   op_load,
    input  logic                   op_store,
    input  logic [1:0]             op_size,
    input  logic                   op_signed,
    input  logic [31:0]            op_addr,
    input  logic [31:0]            op_wdata,
    output logic                   stall,
    output logic                   done,
    output logic [31:0]            load_data,
    output logic                   misalign_err,
    output logic                   bus_err,
    mem_access_sequencer_if.master mem
);

    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : TIMEOUT_CYCLES - 32'd1;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        crossing;
    logic        reject;
    logic        tmo_hit;
    logic        second_beat;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic        store_q;
    logic        misalign_q;
    logic        bus_err_q;
    logic [31:0] rdata1_q;
    logic [31:0] rdata_hi;
    logic [31:0] tmo_count;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_value;

    assign accept   = (state == IDLE) && op_valid && (op_load || op_store);
    assign crossing = crosses_word(op_addr[1:0], op_size);
    assign tmo_hit  = (TIMEOUT_CYCLES != 0) && !mem.mem_ack && (tmo_count == TMO_LAST);

`ifdef MISALIGN_SPLIT_EN
    logic cross_q;
    assign reject      = (op_size == SIZE_BAD);
    assign second_beat = (state == BEAT2);
`else
    assign reject      = (op_size == SIZE_BAD) || crossing;
    assign second_beat = 1'b0;
    assign rdata_hi    = '0;
`endif

    mem_lane_align u_lane_align (
        .off        (addr_q[1:0]),
        .size       (size_q),
        .sign_ext   (signed_q),
        .second_beat(second_beat),
        .wdata      (wdata_q),
        .rdata_lo   (rdata1_q),
        .rdata_hi   (rdata_hi),
        .be         (lane_be),
        .lane_wdata (lane_wdata),
        .load_value (load_value)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = reject ? DONE : BEAT1;
                end
            end
            BEAT1: begin
                if (mem.mem_ack) begin
`ifdef MISALIGN_SPLIT_EN
                    next_state = cross_q ? BEAT2 : DONE;
`else
                    next_state = DONE;
`endif
                end else if (tmo_hit) begin
                    next_state = DONE;
                end
            end
            BEAT2: begin
`ifdef MISALIGN_SPLIT_EN
                if (mem.mem_ack || tmo_hit) begin
                    next_state = DONE;
                end
`else
                next_state = IDLE;
`endif
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operation capture, beat data and the per-beat timeout counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            size_q     <= SIZE_BYTE;
            signed_q   <= 1'b0;
            store_q    <= 1'b0;
            misalign_q <= 1'b0;
            bus_err_q  <= 1'b0;
            rdata1_q   <= '0;
            tmo_count  <= '0;
`ifdef MISALIGN_SPLIT_EN
            cross_q    <= 1'b0;
            rdata_hi   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q     <= op_addr;
                        wdata_q    <= op_wdata;
                        size_q     <= op_size;
                        signed_q   <= op_signed;
                        store_q    <= op_store;
                        misalign_q <= reject;
                        bus_err_q  <= 1'b0;
                        rdata1_q   <= '0;
                        tmo_count  <= '0;
`ifdef MISALIGN_SPLIT_EN
                        cross_q    <= crossing;
                        rdata_hi   <= '0;
`endif
                    end
                end
                BEAT1: begin
                    if (mem.mem_ack) begin
                        rdata1_q  <= mem.mem_rdata;
                        tmo_count <= '0;
                    end else if (tmo_hit) begin
                        bus_err_q <= 1'b1;
                    end else begin
                        tmo_count <= tmo_count + 32'd1;
                    end
                end
`ifdef MISALIGN_SPLIT_EN
                BEAT2: begin
                    if (mem.mem_ack) begin
                        rdata_hi <= mem.mem_rdata;
                    end else if (tmo_hit) begin
                        bus_err_q <= 1'b1;
                    end else begin
                        tmo_count <= tmo_count + 32'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        stall         = accept;
        done          = 1'b0;
        load_data     = '0;
        misalign_err  = 1'b0;
        bus_err       = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_be    = '0;
        mem.mem_wdata = '0;
        case (state)
            BEAT1: begin
                stall         = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = store_q;
                mem.mem_addr  = {addr_q[31:2], 2'b00};
                mem.mem_be    = lane_be;
                mem.mem_wdata = lane_wdata;
            end
`ifdef MISALIGN_SPLIT_EN
            BEAT2: begin
                stall         = 1'b1;
                mem.mem_req   = 1'b1;
                mem.mem_we    = store_q;
                mem.mem_addr  = {addr_q[31:2], 2'b00} + 32'd4;
                mem.mem_be    = lane_be;
                mem.mem_wdata = lane_wdata;
            end
`endif
            DONE: begin
                done         = 1'b1;
                misalign_err = misalign_q;
                bus_err      = bus_err_q;
                load_data    = (store_q || misalign_q || bus_err_q) ? '0 : load_value;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed cases plus random ops checked
// against a byte-addressed memory reference model (MISALIGN_SPLIT_EN aware).
module tb_mem_access_sequencer;

`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif
    localparam int TMO = 4;

    logic        clock;
    logic        reset;
    logic        op_valid;
    logic        op_load;
    logic        op_store;
    logic [1:0]  op_size;
    logic        op_signed;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        bus_err;
    logic        any_out;

    int vectors;
    int miscompares;

    logic [7:0] ref_mem [logic [31:0]];
    logic [7:0] bus_mem [logic [31:0]];

    mem_access_sequencer_if mem_bus ();

    mem_access_sequencer #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock       (clock),
        .reset       (reset),
        .op_valid    (op_valid),
        .op_load     (op_load),
        .op_store    (op_store),
        .op_size     (op_size),
        .op_signed   (op_signed),
        .op_addr     (op_addr),
        .op_wdata    (op_wdata),
        .stall       (stall),
        .done        (done),
        .load_data   (load_data),
        .misalign_err(misalign_err),
        .bus_err     (bus_err),
        .mem         (mem_bus.master)
    );

    assign any_out = stall | done | (|load_data) | misalign_err | bus_err | mem_bus.mem_req |
                     mem_bus.mem_we | (|mem_bus.mem_addr) | (|mem_bus.mem_be) | (|mem_bus.mem_wdata);

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5 ^ {a[1:0], a[31:26]};
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] bus_byte(input logic [31:0] a);
        if (bus_mem.exists(a)) return bus_mem[a];
        return init_byte(a);
    endfunction

    task automatic preload_word(input logic [31:0] word_addr, input logic [31:0] value);
        for (int k = 0; k < 4; k++) begin
            ref_mem[word_addr + 32'(k)] = value[8*k +: 8];
            bus_mem[word_addr + 32'(k)] = value[8*k +: 8];
        end
    endtask

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One memory-stage op: pipeline holds op_valid until done; the bench answers beats
    // from its bus memory after w1/w2 wait cycles, or never when no_ack is set.
    task automatic apply_stimulus(input bit ld, input bit st, input logic [1:0] size, input bit sgn,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input int w1, input int w2, input bit no_ack,
                                  output logic [31:0] obs_load, output logic [31:0] obs_wdata);
        int          n;
        bit          crossing;
        bit          rejected;
        int          exp_beats;
        int          exp_cycles;
        int          beat;
        int          waited;
        int          cyc;
        int          req_cycles;
        bit          seen_done;
        logic [31:0] beat_word [2];
        logic [3:0]  exp_be [2];
        logic [31:0] exp_lane [2];
        logic [31:0] tmp_lane;
        logic [3:0]  tmp_be;
        logic [31:0] ba;
        int          idx;
        logic [31:0] v;
        logic [31:0] exp_load;
        logic [31:0] lane_mask;
        logic [31:0] rword;

        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : (size == 2'b10) ? 4 : 0;
        crossing  = (size != 2'b11) && (int'(addr[1:0]) + n > 4);
        rejected  = (size == 2'b11) || (crossing && !SPLIT);
        exp_beats = rejected ? 0 : (crossing ? 2 : 1);
        beat_word[0] = {addr[31:2], 2'b00};
        beat_word[1] = beat_word[0] + 32'd4;
        for (int b = 0; b < 2; b++) begin
            exp_be[b]   = '0;
            exp_lane[b] = '0;
        end
        v = '0;
        for (int k = 0; k < n; k++) begin
            ba  = addr + 32'(k);
            idx = ({ba[31:2], 2'b00} == beat_word[0]) ? 0 : 1;
            tmp_be = exp_be[idx];
            tmp_be[ba[1:0]] = 1'b1;
            exp_be[idx] = tmp_be;
            tmp_lane = exp_lane[idx];
            tmp_lane[8*int'(ba[1:0]) +: 8] = wdata[8*k +: 8];
            exp_lane[idx] = tmp_lane;
            v[8*k +: 8] = ref_byte(ba);
        end
        if (size == 2'b00 && sgn) v = {{24{v[7]}}, v[7:0]};
        if (size == 2'b01 && sgn) v = {{16{v[15]}}, v[15:0]};
        exp_load = (st || rejected || no_ack) ? 32'd0 : v;
        exp_cycles = 2 + ((exp_beats == 0) ? 0 : no_ack ? TMO :
                          (w1 + 1) + ((exp_beats == 2) ? (w2 + 1) : 0));

        obs_load  = '0;
        obs_wdata = '0;
        @(negedge clock);
        op_valid  = 1'b1;
        op_load   = ld;
        op_store  = st;
        op_size   = size;
        op_signed = sgn;
        op_addr   = addr;
        op_wdata  = wdata;
        #1;
        check_output("accept_stall", 64'(stall), 64'd1);

        cyc = 1; beat = 0; waited = 0; req_cycles = 0; seen_done = 0;
        while (!seen_done && cyc < 40) begin
            @(negedge clock);
            cyc++;
            mem_bus.mem_ack   = 1'b0;
            mem_bus.mem_rdata = $urandom();
            if (done) begin
                seen_done = 1;
                obs_load  = load_data;
                check_output("done_cycle", 64'(cyc), 64'(exp_cycles));
                check_output("done_stall", 64'(stall), 64'd0);
                check_output("load_data", 64'(load_data), 64'(exp_load));
                check_output("err_flags", {62'd0, misalign_err, bus_err}, {62'd0, rejected, no_ack});
                check_output("req_cycles", 64'(req_cycles), 64'(exp_cycles - 2));
                check_output("beats_acked", 64'(beat), 64'(no_ack ? 0 : exp_beats));
                op_valid = 1'b0;
            end else if (mem_bus.mem_req) begin
                req_cycles++;
                if (req_cycles == 1) obs_wdata = mem_bus.mem_wdata;
                if (beat < 2) begin
                    check_output("beat_addr_be_we",
                                 {27'd0, mem_bus.mem_addr, mem_bus.mem_be, mem_bus.mem_we},
                                 {27'd0, beat_word[beat], exp_be[beat], st});
                    lane_mask = {{8{exp_be[beat][3]}}, {8{exp_be[beat][2]}},
                                 {8{exp_be[beat][1]}}, {8{exp_be[beat][0]}}};
                    if (st) check_output("beat_wdata", 64'(mem_bus.mem_wdata & lane_mask), 64'(exp_lane[beat]));
                end
                if (!no_ack && waited == ((beat == 0) ? w1 : w2)) begin
                    for (int l = 0; l < 4; l++) begin
                        ba = mem_bus.mem_addr + 32'(l);
                        rword[8*l +: 8] = bus_byte(ba);
                        if (mem_bus.mem_we && mem_bus.mem_be[l]) bus_mem[ba] = mem_bus.mem_wdata[8*l +: 8];
                    end
                    mem_bus.mem_ack   = 1'b1;
                    mem_bus.mem_rdata = rword;
                    beat++;
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                check_output("busy_stall", 64'(stall), 64'd1);
            end
        end
        check_output("done_seen", 64'(seen_done), 64'd1);
        op_valid = 1'b0;
        mem_bus.mem_ack = 1'b0;

        if (st && !rejected && !no_ack) begin
            for (int k = 0; k < n; k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
        end

        @(negedge clock);
        check_output("after_done_idle", {62'd0, done, stall}, 64'd0);
    endtask

    logic [31:0] obs_load;
    logic [31:0] obs_wdata;

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        op_valid    = 1'b0;
        op_load     = 1'b0;
        op_store    = 1'b0;
        op_size     = 2'b00;
        op_signed   = 1'b0;
        op_addr     = '0;
        op_wdata    = '0;
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;
        $display("[TB] start, split=%0d timeout=%0d", SPLIT, TMO);

        repeat (2) @(negedge clock);
        check_output("reset_outputs", 64'(any_out), 64'd0);
        reset = 1'b0;

        preload_word(32'h100, 32'hDEADBEEF);
        apply_stimulus(1, 0, 2'b10, 0, 32'h100, 32'h0, 0, 0, 0, obs_load, obs_wdata);
        check_output("lw_0x100", 64'(obs_load), 64'hDEADBEEF);

        preload_word(32'h200, 32'h80000000);
        apply_stimulus(1, 0, 2'b00, 1, 32'h203, 32'h0, 1, 0, 0, obs_load, obs_wdata);
        check_output("lb_0x203", 64'(obs_load), 64'hFFFFFF80);
        apply_stimulus(1, 0, 2'b00, 0, 32'h203, 32'h0, 0, 0, 0, obs_load, obs_wdata);
        check_output("lbu_0x203", 64'(obs_load), 64'h00000080);

        apply_stimulus(0, 1, 2'b01, 0, 32'h302, 32'h0000ABCD, 0, 0, 0, obs_load, obs_wdata);
        check_output("sh_0x302_wdata", 64'(obs_wdata), 64'hABCD0000);
        apply_stimulus(1, 0, 2'b01, 0, 32'h302, 32'h0, 0, 0, 0, obs_load, obs_wdata);
        check_output("lhu_after_sh", 64'(obs_load), 64'h0000ABCD);

        preload_word(32'h0FC, 32'h11223344);
        preload_word(32'h100, 32'h55667788);
        apply_stimulus(1, 0, 2'b10, 0, 32'h0FE, 32'h0, 0, 1, 0, obs_load, obs_wdata);
        check_output("lw_0x0FE", 64'(obs_load), SPLIT ? 64'h77881122 : 64'h0);

        apply_stimulus(1, 0, 2'b10, 0, 32'h500, 32'h0, 0, 0, 1, obs_load, obs_wdata);
        apply_stimulus(1, 1, 2'b11, 0, 32'h504, 32'h12345678, 0, 0, 0, obs_load, obs_wdata);
        apply_stimulus(0, 1, 2'b01, 0, 32'hFFFFFFFF, 32'h0000C3D2, 1, 0, 0, obs_load, obs_wdata);
        apply_stimulus(1, 0, 2'b01, 1, 32'hFFFFFFFF, 32'h0, 0, 0, 0, obs_load, obs_wdata);

        // Reset lands while BEAT1 waits; the ack that follows must be ignored.
        @(negedge clock);
        op_valid = 1'b1; op_load = 1'b1; op_store = 1'b0; op_size = 2'b10; op_addr = 32'h700;
        @(negedge clock);
        check_output("rst_mid_req", 64'(mem_bus.mem_req), 64'd1);
        reset = 1'b1;
        op_valid = 1'b0;
        @(negedge clock);
        check_output("rst_mid_outputs", 64'(any_out), 64'd0);
        reset = 1'b0;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'hFFFFFFFF;
        @(negedge clock);
        check_output("late_ack_ignored", {61'd0, done, mem_bus.mem_req, stall}, 64'd0);
        mem_bus.mem_ack = 1'b0;
        @(negedge clock);
        check_output("late_ack_no_done", 64'(done), 64'd0);

        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [1:0]  sz;
            logic [31:0] a;
            kind = int'($urandom_range(0, 3));
            sz   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a    = (($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : 32'h00000600) + 32'($urandom_range(0, 15));
            apply_stimulus(kind != 1 && kind != 3 ? 1'b1 : (kind == 3), kind == 1 || kind == 3, sz,
                           1'($urandom_range(0, 1)), a, $urandom(),
                           int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0,
                           obs_load, obs_wdata);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
